// File: rtl/alu_input_loader_if.sv
// alu_input_loader_if: switch/button inputs and ALU-operand outputs of the loader stage.
interface alu_input_loader_if #(
    parameter int NB_DATA = 4,
    parameter int NB_OP   = 6,
    parameter int NB_SW   = 6
);
    logic [NB_SW-1:0]   i_sw;
    logic [2:0]         i_btn;
    logic [NB_DATA-1:0] o_datoA;
    logic [NB_DATA-1:0] o_datoB;
    logic [NB_OP-1:0]   o_operation;
    logic [2:0]         o_loaded;
    logic               o_ready;
    logic               o_update;

    modport master (
        output i_sw, i_btn,
        input  o_datoA, o_datoB, o_operation, o_loaded, o_ready, o_update
    );

    modport slave (
        input  i_sw, i_btn,
        output o_datoA, o_datoB, o_operation, o_loaded, o_ready, o_update
    );
endinterface

// File: rtl/alu_input_loader.sv
// alu_input_loader: synchronise, debounce and edge-detect three buttons that load
// operand A, operand B and the operation code from the switch bus.
module alu_input_loader #(
    parameter int NB_DATA   = 4,
    parameter int NB_OP     = 6,
    parameter int NB_SW     = 6,
    parameter int DB_CYCLES = 16
) (
    input  logic              clk,
    input  logic              i_rst,
    alu_input_loader_if.slave bus
);
    localparam int NB_CNT = $clog2(DB_CYCLES);
    localparam logic [NB_CNT-1:0] CNT_MAX = NB_CNT'(DB_CYCLES - 1);

    logic [2:0]         r_s1;
    logic [2:0]         r_s2;
    logic [2:0]         r_db;
    logic [2:0]         r_db_d;
    logic [NB_CNT-1:0]  r_cnt [3];
    logic [NB_DATA-1:0] r_datoA;
    logic [NB_DATA-1:0] r_datoB;
    logic [NB_OP-1:0]   r_operation;
    logic [2:0]         r_loaded;
    logic               r_update;
    logic [2:0]         w_load;

    assign w_load = r_db & ~r_db_d;

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_s1        <= '0;
            r_s2        <= '0;
            r_db        <= '0;
            r_db_d      <= '0;
            r_datoA     <= '0;
            r_datoB     <= '0;
            r_operation <= '0;
            r_loaded    <= '0;
            r_update    <= 1'b0;
            for (int k = 0; k < 3; k++) r_cnt[k] <= '0;
        end else begin
            r_s1   <= bus.i_btn;
            r_s2   <= r_s1;
            r_db_d <= r_db;
            // Level must disagree with db for DB_CYCLES consecutive samples to flip it
            for (int k = 0; k < 3; k++) begin
                if (r_s2[k] == r_db[k]) begin
                    r_cnt[k] <= '0;
                end else if (r_cnt[k] == CNT_MAX) begin
                    r_db[k]  <= ~r_db[k];
                    r_cnt[k] <= '0;
                end else begin
                    r_cnt[k] <= r_cnt[k] + 1'b1;
                end
            end
            if (w_load[0]) r_datoA <= bus.i_sw[NB_DATA-1:0];
            if (w_load[1]) r_datoB <= bus.i_sw[NB_DATA-1:0];
            if (w_load[2]) r_operation <= bus.i_sw[NB_OP-1:0];
            r_loaded <= r_loaded | w_load;
            r_update <= |w_load;
        end
    end

    assign bus.o_datoA     = r_datoA;
    assign bus.o_datoB     = r_datoB;
    assign bus.o_operation = r_operation;
    assign bus.o_loaded    = r_loaded;
    assign bus.o_ready     = &r_loaded;
    assign bus.o_update    = r_update;
endmodule

// File: tb/tb_alu_input_loader.sv
// tb_alu_input_loader: directed presses with a scoreboard of expected loads,
// checked (values and latency) whenever o_update pulses.
module tb_alu_input_loader;
    typedef struct {
        int         cyc;
        logic [3:0] a;
        logic [3:0] b;
        logic [5:0] op;
        logic [2:0] ld;
    } exp_t;

    logic clk = 1'b0;
    logic i_rst = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_upd = 0;
    int   exp_upd = 0;
    int   upd0;
    exp_t q[$];
    exp_t m_e;
    logic [3:0] ma, mb;
    logic [5:0] mop;
    logic [2:0] mld;

    alu_input_loader_if #(.NB_DATA(4), .NB_OP(6), .NB_SW(6)) bus ();

    alu_input_loader #(.NB_DATA(4), .NB_OP(6), .NB_SW(6), .DB_CYCLES(4)) dut (
        .clk   (clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, "_A"}, 32'(bus.o_datoA), 32'(ma));
        check({tag, "_B"}, 32'(bus.o_datoB), 32'(mb));
        check({tag, "_OP"}, 32'(bus.o_operation), 32'(mop));
        check({tag, "_LD"}, 32'(bus.o_loaded), 32'(mld));
        check({tag, "_RDY"}, 32'(bus.o_ready), 32'(&mld));
    endtask

    // Expected load: latency of 7 negedges from the drive point (DB_CYCLES=4)
    task automatic expect_load(input logic [2:0] m, input logic [5:0] sw);
        if (m[0]) ma = sw[3:0];
        if (m[1]) mb = sw[3:0];
        if (m[2]) mop = sw;
        mld |= m;
        q.push_back('{cyc + 7, ma, mb, mop, mld});
        exp_upd++;
    endtask

    always @(negedge clk) begin
        if (bus.o_update === 1'b1) begin
            n_upd++;
            if (q.size() == 0) begin
                check("spurious_update_queue", 32'(q.size()), 32'd1);
            end else begin
                m_e = q.pop_front();
                check("upd_latency", 32'(cyc), 32'(m_e.cyc));
                check("upd_A", 32'(bus.o_datoA), 32'(m_e.a));
                check("upd_B", 32'(bus.o_datoB), 32'(m_e.b));
                check("upd_OP", 32'(bus.o_operation), 32'(m_e.op));
                check("upd_LD", 32'(bus.o_loaded), 32'(m_e.ld));
                check("upd_RDY", 32'(bus.o_ready), 32'(&m_e.ld));
            end
        end
    end

    task automatic do_reset(input logic [2:0] btn, input logic [5:0] sw);
        @(negedge clk);
        i_rst = 1'b1;
        bus.i_btn = btn;
        bus.i_sw = sw;
        repeat (3) begin
            @(negedge clk);
            check("rst_A", 32'(bus.o_datoA), 32'd0);
            check("rst_B", 32'(bus.o_datoB), 32'd0);
            check("rst_OP", 32'(bus.o_operation), 32'd0);
            check("rst_LD", 32'(bus.o_loaded), 32'd0);
            check("rst_RDY", 32'(bus.o_ready), 32'd0);
            check("rst_UPD", 32'(bus.o_update), 32'd0);
        end
        i_rst = 1'b0;
        ma = '0;
        mb = '0;
        mop = '0;
        mld = '0;
        if (btn != 3'b000) expect_load(btn, sw);
    endtask

    task automatic press(input logic [2:0] m, input logic [5:0] sw, input int hold);
        @(negedge clk);
        bus.i_sw = sw;
        bus.i_btn = m;
        expect_load(m, sw);
        repeat (hold) @(negedge clk);
        bus.i_btn = 3'b000;
        repeat (12) @(negedge clk);
    endtask

    initial begin
        bus.i_btn = 3'b000;
        bus.i_sw = 6'b000000;
        // Buttons held through reset load all registers once after release
        do_reset(3'b111, 6'b000111);
        repeat (12) @(negedge clk);
        bus.i_btn = 3'b000;
        repeat (12) @(negedge clk);
        check_model("rst_held");

        do_reset(3'b000, 6'b000000);
        repeat (4) @(negedge clk);
        check_model("idle");

        press(3'b001, 6'b000011, 10);
        check_model("load_A");
        press(3'b010, 6'b000101, 10);
        check_model("load_B");
        press(3'b100, 6'b100000, 10);
        check_model("load_OP");
        check("alu_sum", 32'(bus.o_datoA + bus.o_datoB), 32'd8);

        upd0 = n_upd;
        @(negedge clk);
        bus.i_sw = 6'b001111;
        for (int i = 0; i < 10; i++) begin
            bus.i_btn = 3'b001;
            repeat (2) @(negedge clk);
            bus.i_btn = 3'b000;
            repeat (2) @(negedge clk);
        end
        repeat (12) @(negedge clk);
        check_model("bounce");
        check("bounce_upd", 32'(n_upd - upd0), 32'd0);

        upd0 = n_upd;
        @(negedge clk);
        bus.i_sw = 6'b000001;
        bus.i_btn = 3'b010;
        expect_load(3'b010, 6'b000001);
        repeat (20) @(negedge clk);
        bus.i_sw = 6'b000010;
        repeat (30) @(negedge clk);
        bus.i_btn = 3'b000;
        repeat (12) @(negedge clk);
        check_model("hold");
        check("hold_upd", 32'(n_upd - upd0), 32'd1);

        upd0 = n_upd;
        press(3'b101, 6'b100010, 10);
        check_model("simul");
        check("simul_upd", 32'(n_upd - upd0), 32'd1);

        check("queue_empty", 32'(q.size()), 32'd0);
        check("upd_count", 32'(n_upd), 32'(exp_upd));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
